alu_stream: RTL and testbench

Parametrised, fully handshaked successor to the existing ALU: one AXI-Stream operand port, one AXI-Stream result port with backpressure, and four in-house operations (add, sub, multiply, divide) with no vendor arithmetic cores. It holds one operation in flight, executes it on a dedicated datapath and keeps the result stable until the downstream consumer accepts it. Status flags for divide-by-zero and overflow travel with the result. It sits between the command decoder and the result sink, in place of the fixed-width ALU.

---
 rtl/alu_stream_pkg.sv | 20 ++
 rtl/alu_stream_if.sv | 33 +++
 rtl/alu_div_iter.sv | 75 +++++++
 rtl/alu_stream.sv | 185 ++++++++++++++++++
 tb/tb_alu_stream.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/alu_stream_pkg.sv
// alu_stream shared definitions: opcodes, result flag indices, FSM states.
// Imported by the ALU top, its interface and the testbench.
package alu_stream_pkg;

    localparam logic [1:0] OPP_ADD = 2'd0;
    localparam logic [1:0] OPP_SUB = 2'd1;
    localparam logic [1:0] OPP_MUL = 2'd2;
    localparam logic [1:0] OPP_DIV = 2'd3;

    localparam int FLAG_DIV0 = 0;
    localparam int FLAG_OVF  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_stream_if.sv
// alu_stream bus bundle: operand stream in, result stream out.
// master = command side (drives operands, accepts results); slave = ALU side.
interface alu_stream_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int ALU_OPP_WIDTH = 2
);
    logic [ALU_OPP_WIDTH-1:0] i_alu_opp;
    logic [DATA_WIDTH-1:0]    s_axis_a_tdata;
    logic                     s_axis_a_tvalid;
    logic                     s_axis_a_tready;
    logic [DATA_WIDTH-1:0]    s_axis_b_tdata;
    logic [DATA_WIDTH-1:0]    m_axis_result_tdata;
    logic [DATA_WIDTH-1:0]    m_axis_result_trem;
    logic [1:0]               m_axis_result_tuser;
    logic                     m_axis_result_tvalid;
    logic                     m_axis_result_tready;

    modport master (
        output i_alu_opp, s_axis_a_tdata, s_axis_a_tvalid,
        output s_axis_b_tdata, m_axis_result_tready,
        input  s_axis_a_tready, m_axis_result_tdata,
        input  m_axis_result_trem, m_axis_result_tuser,
        input  m_axis_result_tvalid
    );

    modport slave (
        input  i_alu_opp, s_axis_a_tdata, s_axis_a_tvalid,
        input  s_axis_b_tdata, m_axis_result_tready,
        output s_axis_a_tready, m_axis_result_tdata,
        output m_axis_result_trem, m_axis_result_tuser,
        output m_axis_result_tvalid
    );
endinterface

// File: rtl/alu_div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// Ports: start/dividend/divisor in; quotient/remainder valid while done=1.
module alu_div_iter #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  done
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W:0]    r_sh, r_diff;
    logic [W-1:0]  step_r, step_q;

    // Sign bit of the W+1 wide trial subtraction selects restore vs keep.
    always_comb begin
        r_sh   = {rem_q, quo_q[W-1]};
        r_diff = r_sh - {1'b0, dvs_q};
        if (r_diff[W]) begin
            step_r = r_sh[W-1:0];
            step_q = {quo_q[W-2:0], 1'b0};
        end else begin
            step_r = r_diff[W-1:0];
            step_q = {quo_q[W-2:0], 1'b1};
        end
    end

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = CW'(W);
        end else if (cnt_q != '0) begin
            rem_d = step_r;
            quo_d = step_q;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    // Final step is presented combinationally so the caller can
    // register it on the same edge the last bit resolves.
    assign done      = (cnt_q == CW'(1));
    assign quotient  = step_q;
    assign remainder = step_r;

endmodule

// File: rtl/alu_stream.sv
// Handshaked ALU: ADD/SUB/MUL/DIV, one op in flight, result held until taken.
// Ports: aclk/aresetn, operand stream (opp,A,B), result stream (data,rem,flags).
module alu_stream
    import alu_stream_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int ALU_OPP_WIDTH = 2,
    parameter int MUL_STAGES    = 3
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [ALU_OPP_WIDTH-1:0] i_alu_opp,
    input  logic [DATA_WIDTH-1:0]    s_axis_a_tdata,
    input  logic                     s_axis_a_tvalid,
    output logic                     s_axis_a_tready,
    input  logic [DATA_WIDTH-1:0]    s_axis_b_tdata,
    output logic [DATA_WIDTH-1:0]    m_axis_result_tdata,
    output logic [DATA_WIDTH-1:0]    m_axis_result_trem,
    output logic [1:0]               m_axis_result_tuser,
    output logic                     m_axis_result_tvalid,
    input  logic                     m_axis_result_tready
);
    localparam int W   = DATA_WIDTH;
    localparam int S   = MUL_STAGES;
    localparam int MCW = (S > 1) ? $clog2(S) : 1;

    state_t         state_q, state_d;
    logic [W-1:0]   tdata_q, tdata_d;
    logic [W-1:0]   trem_q, trem_d;
    logic [1:0]     tuser_q, tuser_d;
    logic [MCW-1:0] mul_cnt_q, mul_cnt_d;

    logic [1:0]     opp;
    logic [W:0]     sum;
    logic [W-1:0]   diff;
    logic [2*W-1:0] prod;
    logic [W-1:0]   mul_lo_d;
    logic           mul_ovf_d;
    logic [W-1:0]   mul_lo_q [S];
    logic           mul_ovf_q [S];

    logic           div_start;
    logic [W-1:0]   div_quo, div_rem;
    logic           div_done;
    logic           unused_opp;

    assign opp        = i_alu_opp[1:0];
    assign unused_opp = ^i_alu_opp;

    assign sum  = {1'b0, s_axis_a_tdata} + {1'b0, s_axis_b_tdata};
    assign diff = s_axis_a_tdata - s_axis_b_tdata;
    assign prod = {{W{1'b0}}, s_axis_a_tdata}
                * {{W{1'b0}}, s_axis_b_tdata};

    assign mul_lo_d  = prod[W-1:0];
    assign mul_ovf_d = |prod[2*W-1:W];

    // Free-running chain: stage 0 captures the product on the accept
    // edge, so the last stage holds it MUL_STAGES-1 edges later.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < S; i++) begin
                mul_lo_q[i]  <= '0;
                mul_ovf_q[i] <= 1'b0;
            end
        end else begin
            mul_lo_q[0]  <= mul_lo_d;
            mul_ovf_q[0] <= mul_ovf_d;
            for (int i = 1; i < S; i++) begin
                mul_lo_q[i]  <= mul_lo_q[i-1];
                mul_ovf_q[i] <= mul_ovf_q[i-1];
            end
        end
    end

    alu_div_iter #(
        .DATA_WIDTH(W)
    ) u_div (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .start     (div_start),
        .dividend  (s_axis_a_tdata),
        .divisor   (s_axis_b_tdata),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    always_comb begin
        state_d   = state_q;
        tdata_d   = tdata_q;
        trem_d    = trem_q;
        tuser_d   = tuser_q;
        mul_cnt_d = mul_cnt_q;
        div_start = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (s_axis_a_tvalid) begin
                    case (opp)
                        OPP_ADD: begin
                            tdata_d           = sum[W-1:0];
                            trem_d            = '0;
                            tuser_d           = '0;
                            tuser_d[FLAG_OVF] = sum[W];
                            state_d           = ST_OUT;
                        end
                        OPP_SUB: begin
                            tdata_d           = diff;
                            trem_d            = '0;
                            tuser_d           = '0;
                            tuser_d[FLAG_OVF] = s_axis_a_tdata
                                              < s_axis_b_tdata;
                            state_d           = ST_OUT;
                        end
                        OPP_MUL: begin
                            mul_cnt_d = '0;
                            state_d   = ST_MUL;
                        end
                        default: begin
                            if (s_axis_b_tdata == '0) begin
                                tdata_d            = '1;
                                trem_d             = s_axis_a_tdata;
                                tuser_d            = '0;
                                tuser_d[FLAG_DIV0] = 1'b1;
                                state_d            = ST_OUT;
                            end else begin
                                div_start = 1'b1;
                                state_d   = ST_DIV;
                            end
                        end
                    endcase
                end
            end
            ST_MUL: begin
                if (mul_cnt_q == MCW'(S - 1)) begin
                    tdata_d           = mul_lo_q[S-1];
                    trem_d            = '0;
                    tuser_d           = '0;
                    tuser_d[FLAG_OVF] = mul_ovf_q[S-1];
                    state_d           = ST_OUT;
                end else begin
                    mul_cnt_d = mul_cnt_q + 1'b1;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    tdata_d = div_quo;
                    trem_d  = div_rem;
                    tuser_d = '0;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (m_axis_result_tready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            tdata_q   <= '0;
            trem_q    <= '0;
            tuser_q   <= '0;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tdata_q   <= tdata_d;
            trem_q    <= trem_d;
            tuser_q   <= tuser_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    // Gated with aresetn so the port reads 0 while reset is held.
    assign s_axis_a_tready      = (state_q == ST_IDLE) & aresetn;
    assign m_axis_result_tvalid = (state_q == ST_OUT);
    assign m_axis_result_tdata  = tdata_q;
    assign m_axis_result_trem   = trem_q;
    assign m_axis_result_tuser  = tuser_q;

endmodule

// File: tb/tb_alu_stream.sv
// Directed scoreboard bench for alu_stream (64-bit, 3 multiplier stages).
// Expected results are queued at send time and popped when results appear.
module tb_alu_stream;
    import alu_stream_pkg::*;

    localparam int W = 64;
    localparam int S = 3;

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] rem;
        logic [1:0]   user;
        int           lat;
    } exp_t;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    alu_stream_if #(.DATA_WIDTH(W), .ALU_OPP_WIDTH(2)) bus ();

    alu_stream #(
        .DATA_WIDTH    (W),
        .ALU_OPP_WIDTH (2),
        .MUL_STAGES    (S)
    ) dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .i_alu_opp            (bus.i_alu_opp),
        .s_axis_a_tdata       (bus.s_axis_a_tdata),
        .s_axis_a_tvalid      (bus.s_axis_a_tvalid),
        .s_axis_a_tready      (bus.s_axis_a_tready),
        .s_axis_b_tdata       (bus.s_axis_b_tdata),
        .m_axis_result_tdata  (bus.m_axis_result_tdata),
        .m_axis_result_trem   (bus.m_axis_result_trem),
        .m_axis_result_tuser  (bus.m_axis_result_tuser),
        .m_axis_result_tvalid (bus.m_axis_result_tvalid),
        .m_axis_result_tready (bus.m_axis_result_tready)
    );

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ed,
                        input logic [W-1:0] er, input logic [1:0] eu,
                        input int lat, input bit push);
        exp_t e;
        int   t = 0;
        @(negedge aclk);
        bus.i_alu_opp       = op;
        bus.s_axis_a_tdata  = a;
        bus.s_axis_b_tdata  = b;
        bus.s_axis_a_tvalid = 1'b1;
        while (!bus.s_axis_a_tready && t < 200) begin
            @(negedge aclk);
            t++;
        end
        chk("send_wait", W'(t < 200), W'(1));
        @(posedge aclk);
        #1;
        // Scribble the inputs: the held operation must ignore them.
        bus.s_axis_a_tvalid = 1'b0;
        bus.s_axis_a_tdata  = {$urandom, $urandom};
        bus.s_axis_b_tdata  = {$urandom, $urandom};
        bus.i_alu_opp       = 2'($urandom);
        if (push) begin
            e.data = ed;
            e.rem  = er;
            e.user = eu;
            e.lat  = lat;
            sb.push_back(e);
        end
    endtask

    task automatic collect(input string tag);
        exp_t e;
        int   lat = 1;
        chk({tag, ".sb"}, W'(sb.size() > 0), W'(1));
        if (sb.size() == 0) return;
        e = sb.pop_front();
        @(negedge aclk);
        while (!bus.m_axis_result_tvalid && lat < 300) begin
            @(negedge aclk);
            lat++;
        end
        chk({tag, ".lat"},  W'(lat), W'(e.lat));
        chk({tag, ".data"}, bus.m_axis_result_tdata, e.data);
        chk({tag, ".rem"},  bus.m_axis_result_trem, e.rem);
        chk({tag, ".user"}, W'(bus.m_axis_result_tuser), W'(e.user));
        chk({tag, ".busy"}, W'(bus.s_axis_a_tready), W'(0));
        if (bus.m_axis_result_tready) begin
            @(negedge aclk);
            chk({tag, ".vdrop"}, W'(bus.m_axis_result_tvalid), W'(0));
            chk({tag, ".rdy"}, W'(bus.s_axis_a_tready), W'(1));
        end
    endtask

    initial begin
        bus.i_alu_opp            = '0;
        bus.s_axis_a_tdata       = '0;
        bus.s_axis_b_tdata       = '0;
        bus.s_axis_a_tvalid      = 1'b0;
        bus.m_axis_result_tready = 1'b0;

        repeat (3) @(negedge aclk);
        chk("rst.a_tready", W'(bus.s_axis_a_tready), W'(0));
        chk("rst.tvalid", W'(bus.m_axis_result_tvalid), W'(0));
        chk("rst.tdata", bus.m_axis_result_tdata, W'(0));
        chk("rst.trem", bus.m_axis_result_trem, W'(0));
        chk("rst.tuser", W'(bus.m_axis_result_tuser), W'(0));
        aresetn = 1'b1;
        bus.m_axis_result_tready = 1'b1;
        @(negedge aclk);
        chk("rel.a_tready", W'(bus.s_axis_a_tready), W'(1));

        send(OPP_ADD, '1, 64'd1, 64'd0, 64'd0, 2'b10, 1, 1'b1);
        collect("add_carry");
        send(OPP_ADD, 64'd10, 64'd20, 64'd30, 64'd0, 2'b00, 1, 1'b1);
        collect("add_plain");
        send(OPP_SUB, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0,
             2'b10, 1, 1'b1);
        collect("sub_borrow");
        send(OPP_SUB, 64'd7, 64'd5, 64'd2, 64'd0, 2'b00, 1, 1'b1);
        collect("sub_plain");

        // (2^32)*(2^32+1) = 2^64 + 2^32: low half 2^32, high half nonzero.
        send(OPP_MUL, 64'h1_0000_0000, 64'h1_0000_0001,
             64'h1_0000_0000, 64'd0, 2'b10, S + 1, 1'b1);
        collect("mul_ovf");
        send(OPP_MUL, 64'd6, 64'd7, 64'd42, 64'd0, 2'b00, S + 1, 1'b1);
        collect("mul_small");
        send(OPP_MUL, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0,
             2'b10, S + 1, 1'b1);
        collect("mul_max");

        send(OPP_DIV, 64'd100, 64'd7, 64'd14, 64'd2, 2'b00, W + 1, 1'b1);
        collect("div_100_7");
        send(OPP_DIV, 64'd9, 64'd0, '1, 64'd9, 2'b01, 1, 1'b1);
        collect("div_zero");
        send(OPP_DIV, '1, 64'd1, '1, 64'd0, 2'b00, W + 1, 1'b1);
        collect("div_max");
        send(OPP_DIV, 64'd5, 64'd9, 64'd0, 64'd5, 2'b00, W + 1, 1'b1);
        collect("div_small");

        bus.m_axis_result_tready = 1'b0;
        send(OPP_ADD, 64'd3, 64'd4, 64'd7, 64'd0, 2'b00, 1, 1'b1);
        collect("bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            chk("bp.hold_v", W'(bus.m_axis_result_tvalid), W'(1));
            chk("bp.hold_d", bus.m_axis_result_tdata, W'(7));
            chk("bp.hold_r", W'(bus.s_axis_a_tready), W'(0));
        end
        bus.m_axis_result_tready = 1'b1;
        @(negedge aclk);
        chk("bp.vdrop", W'(bus.m_axis_result_tvalid), W'(0));
        chk("bp.rdy", W'(bus.s_axis_a_tready), W'(1));

        send(OPP_DIV, 64'd100, 64'd7, '0, '0, 2'b00, 0, 1'b0);
        repeat (19) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        #1;
        chk("mid.tvalid", W'(bus.m_axis_result_tvalid), W'(0));
        chk("mid.tdata", bus.m_axis_result_tdata, W'(0));
        chk("mid.trem", bus.m_axis_result_trem, W'(0));
        chk("mid.tuser", W'(bus.m_axis_result_tuser), W'(0));
        chk("mid.a_tready", W'(bus.s_axis_a_tready), W'(0));
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("mid.rel_rdy", W'(bus.s_axis_a_tready), W'(1));
        send(OPP_ADD, 64'd1, 64'd1, 64'd2, 64'd0, 2'b00, 1, 1'b1);
        collect("post_rst");
        repeat (W + 5) @(negedge aclk);
        chk("post_rst.stale", W'(bus.m_axis_result_tvalid), W'(0));
        chk("sb.empty", W'(sb.size()), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
